// File: rtl/uart_pkg.sv
// Shared UART types, constants and the data-length encoding used by TX and RX.
package uart_pkg;

    localparam int unsigned OVERSAMPLE    = 16;
    localparam int unsigned MID_SAMPLE    = 7;
    localparam int unsigned MIN_DATA_BITS = 5;
    localparam int unsigned MAX_DATA_BITS = 8;
    localparam int unsigned CNT_W         = 4;
    localparam int unsigned BIT_CNT_W     = 4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } rx_state_t;

    typedef enum logic [1:0] {
        DATA_BITS_5 = 2'd0,
        DATA_BITS_6 = 2'd1,
        DATA_BITS_7 = 2'd2,
        DATA_BITS_8 = 2'd3
    } data_bits_t;

    // Number of data bits carried by a frame for a given encoding.
    function automatic logic [BIT_CNT_W-1:0] data_bits_len(input logic [1:0] enc);
        return BIT_CNT_W'(MIN_DATA_BITS) + BIT_CNT_W'(enc);
    endfunction

endpackage

// File: rtl/sync_fifo_with_clear.sv
// Single-clock FIFO with synchronous flush; read data is registered.
module sync_fifo_with_clear #(
    parameter int unsigned DATA_WIDTH            = 8,
    parameter int unsigned DEPTH                 = 16,
    parameter int unsigned EXTRA_OUTPUT_REGISTER = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic [AW:0]           count_nxt;
    logic [DATA_WIDTH-1:0] head;
    logic                  do_rd;
    logic                  do_wr;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a write.
    assign do_rd = rd_en && !empty && !clear;
    assign do_wr = wr_en && (!full || do_rd) && !clear;

    // Occupancy after this cycle's operations.
    always_comb begin
        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else if (do_wr && !do_rd) begin
            count_nxt = count + (AW+1)'(1);
        end else if (do_rd && !do_wr) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy, registered flags and head-of-queue data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            head   <= '0;
        end else begin
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == (AW+1)'(DEPTH));
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_wr) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (do_rd) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    head   <= mem[rd_ptr];
                end
            end
        end
    end

    generate
        if (EXTRA_OUTPUT_REGISTER != 0) begin : g_out_reg
            // Optional extra pipeline stage on the read data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data <= '0;
                end else begin
                    rd_data <= head;
                end
            end
        end else begin : g_no_out_reg
            assign rd_data = head;
        end
    endgenerate

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/parity/stop decoding into a byte FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_parity,
    input  logic [1:0] i_data_bits,
    input  logic       i_stop_bits,
    input  logic       i_use_parity,
    input  logic       i_rx_strb,
    output logic       o_rx_strb_en,
    input  logic       i_uart_rx,
    input  logic       i_fifo_rd_en,
    output logic [7:0] o_fifo_rd_data,
    input  logic       i_fifo_clear,
    output logic       o_fifo_empty,
    output logic       o_fifo_full,
    input  logic       i_error_clear,
    output logic       o_overflow_error,
    output logic       o_parity_error,
    output logic       o_frame_error
);

    rx_state_t              state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev;
    logic [CNT_W-1:0]       cnt;
    logic [BIT_CNT_W-1:0]   nbits;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   use_par;
    logic                   par_run;
    logic                   parity_bad;
    logic [7:0]             shreg;
    logic [7:0]             wr_byte;
    logic                   wr_pulse;
    logic                   mid_bit;
    logic                   bit_end;

    // The second stop bit is never checked, so its setting does not reach the datapath.
    logic unused_stop_bits;
    assign unused_stop_bits = i_stop_bits;

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign mid_bit = i_rx_strb && (cnt == CNT_W'(MID_SAMPLE));
    assign bit_end = i_rx_strb && (cnt == CNT_W'(OVERSAMPLE - 1));

    // Metastability synchroniser and edge-detect history; idle level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], i_uart_rx};
            rx_prev <= rx_s;
        end
    end

    // Frame FSM with strobe counter, deserialiser and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            o_rx_strb_en     <= 1'b0;
            cnt              <= '0;
            nbits            <= BIT_CNT_W'(MAX_DATA_BITS);
            bit_cnt          <= '0;
            use_par          <= 1'b0;
            par_run          <= 1'b0;
            parity_bad       <= 1'b0;
            shreg            <= '0;
            wr_byte          <= '0;
            wr_pulse         <= 1'b0;
            o_overflow_error <= 1'b0;
            o_parity_error   <= 1'b0;
            o_frame_error    <= 1'b0;
        end else begin
            wr_pulse <= 1'b0;
            if (i_rx_strb) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (i_error_clear) begin
                o_overflow_error <= 1'b0;
                o_parity_error   <= 1'b0;
                o_frame_error    <= 1'b0;
            end
            // Write lands one cycle after the stop sample; clear and same-cycle read both suppress overflow.
            if (wr_pulse && o_fifo_full && !i_fifo_rd_en && !i_fifo_clear) begin
                o_overflow_error <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state        <= START;
                        o_rx_strb_en <= 1'b1;
                        cnt          <= '0;
                        nbits        <= data_bits_len(i_data_bits);
                        use_par      <= i_use_parity;
                        par_run      <= i_parity;
                        parity_bad   <= 1'b0;
                        bit_cnt      <= '0;
                    end
                end
                START: begin
                    if (mid_bit) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state        <= IDLE;
                            o_rx_strb_en <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        par_run <= par_run ^ rx_s;
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == nbits - BIT_CNT_W'(1)) begin
                            cnt   <= '0;
                            state <= use_par ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        parity_bad <= (rx_s != par_run);
                        cnt        <= '0;
                        state      <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (rx_s) begin
                            wr_pulse     <= 1'b1;
                            wr_byte      <= shreg >> (BIT_CNT_W'(MAX_DATA_BITS) - nbits);
                            state        <= IDLE;
                            o_rx_strb_en <= 1'b0;
                            if (parity_bad) begin
                                o_parity_error <= 1'b1;
                            end
                        end else begin
                            o_frame_error <= 1'b1;
                            state         <= BREAK_WAIT;
                        end
                    end
                end
                BREAK_WAIT: begin
                    if (rx_s) begin
                        cnt          <= '0;
                        state        <= IDLE;
                        o_rx_strb_en <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    o_rx_strb_en <= 1'b0;
                end
            endcase
        end
    end

    sync_fifo_with_clear #(
        .DATA_WIDTH           (8),
        .DEPTH                (FIFO_DEPTH),
        .EXTRA_OUTPUT_REGISTER(0)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (i_fifo_clear),
        .wr_en  (wr_pulse),
        .wr_data(wr_byte),
        .rd_en  (i_fifo_rd_en),
        .rd_data(o_fifo_rd_data),
        .empty  (o_fifo_empty),
        .full   (o_fifo_full)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: vector table of frame formats plus hand-written corner sequences.
module tb_uart_rx;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_parity = 1'b0;
    logic [1:0] i_data_bits = 2'd3;
    logic       i_stop_bits = 1'b0;
    logic       i_use_parity = 1'b0;
    logic       i_rx_strb = 1'b1;
    logic       o_rx_strb_en;
    logic       i_uart_rx = 1'b1;
    logic       i_fifo_rd_en = 1'b0;
    logic [7:0] o_fifo_rd_data;
    logic       i_fifo_clear = 1'b0;
    logic       o_fifo_empty;
    logic       o_fifo_full;
    logic       i_error_clear = 1'b0;
    logic       o_overflow_error;
    logic       o_parity_error;
    logic       o_frame_error;

    int checks = 0;
    int failures = 0;
    int model_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        int         nb;
        bit         use_par;
        bit         seed;
        bit         bad_par;
        bit         exp_perr;
    } vec_t;

    vec_t vecs[7];

    uart_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_parity        (i_parity),
        .i_data_bits     (i_data_bits),
        .i_stop_bits     (i_stop_bits),
        .i_use_parity    (i_use_parity),
        .i_rx_strb       (i_rx_strb),
        .o_rx_strb_en    (o_rx_strb_en),
        .i_uart_rx       (i_uart_rx),
        .i_fifo_rd_en    (i_fifo_rd_en),
        .o_fifo_rd_data  (o_fifo_rd_data),
        .i_fifo_clear    (i_fifo_clear),
        .o_fifo_empty    (o_fifo_empty),
        .o_fifo_full     (o_fifo_full),
        .i_error_clear   (i_error_clear),
        .o_overflow_error(o_overflow_error),
        .o_parity_error  (o_parity_error),
        .o_frame_error   (o_frame_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_bit(input logic b);
        i_uart_rx = b;
        repeat (16) tick();
    endtask

    // Drives one frame and records the byte the FIFO should receive.
    task automatic send_frame(input logic [7:0] d, input int nb, input bit up, input bit seed,
                              input bit bad, input bit stop_lvl, input bit two_stop);
        logic [7:0] m;
        logic [7:0] mask;
        bit p;
        mask = 8'hFF >> (8 - nb);
        m = d & mask;
        p = seed ^ (^m) ^ bad;
        i_data_bits  = 2'(nb - 5);
        i_use_parity = up;
        i_parity     = seed;
        i_stop_bits  = two_stop;
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(m[i]);
        if (up) drive_bit(p);
        drive_bit(stop_lvl);
        if (two_stop) drive_bit(1'b1);
        if (stop_lvl && model_cnt < DEPTH) begin
            exp_q.push_back(m);
            model_cnt++;
        end
    endtask

    // Pops one byte from the DUT and compares it against the scoreboard head.
    task automatic read_check(input string nm);
        logic [7:0] e;
        i_fifo_rd_en = 1'b1;
        tick();
        i_fifo_rd_en = 1'b0;
        if (exp_q.size() == 0) begin
            chk({nm, "_unexpected"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            model_cnt--;
            chk(nm, int'(o_fifo_rd_data), int'(e));
        end
    endtask

    task automatic wait_not_empty(input string nm);
        int n;
        n = 0;
        while (o_fifo_empty && n < 64) begin
            tick();
            n++;
        end
        chk({nm, "_not_empty"}, int'(o_fifo_empty), 0);
    endtask

    task automatic pulse_error_clear();
        i_error_clear = 1'b1;
        tick();
        i_error_clear = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h55, 7, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{8'h55, 7, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h3A, 6, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h13, 5, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0};

        repeat (3) tick();
        chk("rst_strb_en", int'(o_rx_strb_en), 0);
        chk("rst_empty", int'(o_fifo_empty), 1);
        chk("rst_full", int'(o_fifo_full), 0);
        chk("rst_rd_data", int'(o_fifo_rd_data), 0);
        chk("rst_errors", int'({o_overflow_error, o_parity_error, o_frame_error}), 0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Table of frame formats.
        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].data, vecs[v].nb, vecs[v].use_par, vecs[v].seed,
                       vecs[v].bad_par, 1'b1, 1'b0);
            drive_bit(1'b1);
            wait_not_empty($sformatf("v%0d", v));
            chk($sformatf("v%0d_strb_en_idle", v), int'(o_rx_strb_en), 0);
            chk($sformatf("v%0d_perr", v), int'(o_parity_error), int'(vecs[v].exp_perr));
            chk($sformatf("v%0d_ferr", v), int'(o_frame_error), 0);
            chk($sformatf("v%0d_ovf", v), int'(o_overflow_error), 0);
            read_check($sformatf("v%0d_data", v));
            tick();
            chk($sformatf("v%0d_empty_after", v), int'(o_fifo_empty), 1);
            pulse_error_clear();
            chk($sformatf("v%0d_perr_cleared", v), int'(o_parity_error), 0);
        end

        // 5N2 back-to-back frames.
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h03, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive_bit(1'b1);
        read_check("b2b_first");
        read_check("b2b_second");
        tick();
        chk("b2b_empty", int'(o_fifo_empty), 1);

        // Start-bit glitch: too short to survive the mid-bit check.
        i_data_bits = 2'd3;
        i_use_parity = 1'b0;
        i_stop_bits = 1'b0;
        i_uart_rx = 1'b0;
        repeat (6) tick();
        chk("glitch_strb_en_active", int'(o_rx_strb_en), 1);
        i_uart_rx = 1'b1;
        repeat (40) tick();
        chk("glitch_strb_en", int'(o_rx_strb_en), 0);
        chk("glitch_empty", int'(o_fifo_empty), 1);
        chk("glitch_errors", int'({o_overflow_error, o_parity_error, o_frame_error}), 0);

        // Break: held low for 30 bit times, then a normal frame.
        i_uart_rx = 1'b0;
        repeat (30 * 16) tick();
        chk("break_ferr", int'(o_frame_error), 1);
        chk("break_empty", int'(o_fifo_empty), 1);
        chk("break_strb_en", int'(o_rx_strb_en), 1);
        i_uart_rx = 1'b1;
        repeat (20) tick();
        chk("break_released", int'(o_rx_strb_en), 0);
        pulse_error_clear();
        chk("break_ferr_cleared", int'(o_frame_error), 0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_bit(1'b1);
        wait_not_empty("after_break");
        read_check("after_break_data");
        chk("after_break_ferr", int'(o_frame_error), 0);

        // Overflow: one frame more than the FIFO holds.
        tick();
        for (int f = 0; f < DEPTH + 1; f++) begin
            send_frame(8'(f * 13 + 7), 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        drive_bit(1'b1);
        chk("ovf_full", int'(o_fifo_full), 1);
        chk("ovf_flag", int'(o_overflow_error), 1);
        chk("ovf_model_cnt", model_cnt, DEPTH);
        for (int r = 0; r < 4; r++) read_check($sformatf("ovf_head%0d", r));
        tick();
        chk("ovf_not_full", int'(o_fifo_full), 0);
        i_fifo_clear = 1'b1;
        tick();
        i_fifo_clear = 1'b0;
        tick();
        chk("clear_empty", int'(o_fifo_empty), 1);
        exp_q.delete();
        model_cnt = 0;
        pulse_error_clear();
        chk("ovf_cleared", int'(o_overflow_error), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side counterpart of the UART transmitter. It consumes the serial line the TX stage drives, either through the external pin or an internal loopback.
- Oversamples the line at 16x baud, validates the start bit, deserialises 5-8 data bits LSB-first, checks optional parity and the stop bit, and pushes received bytes into a receive FIFO read by the AXI4-Lite register block.
- Frame configuration inputs match the TX stage exactly, so one register set drives both directions.

Parameters:
- FIFO_DEPTH, 16, receive FIFO depth in bytes; power of two, at least 2.
- SYNC_STAGES, 2, number of metastability flops on i_uart_rx; minimum 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- i_parity  in  1  parity seed: 0 = even, 1 = odd (expected parity = i_parity XOR data bits)
- i_data_bits  in  2  data length = 5 + value (5..8 bits)
- i_stop_bits  in  1  0 = one stop bit, 1 = two stop bits
- i_use_parity  in  1  1 = a parity bit follows the data
- i_rx_strb  in  1  single-cycle pulse at 16x baud, from the shared strobe generator
- o_rx_strb_en  out  1  asks the strobe generator to run; high whenever state != IDLE
- i_uart_rx  in  1  asynchronous serial input; idle level is high
- i_fifo_rd_en  in  1  pops one byte
- o_fifo_rd_data  out  8  head byte, right-justified, unused upper bits 0; valid the cycle after i_fifo_rd_en
- i_fifo_clear  in  1  synchronous flush of the FIFO
- o_fifo_empty  out  1  FIFO empty
- o_fifo_full  out  1  FIFO full
- i_error_clear  in  1  single-cycle pulse that clears all three sticky error flags
- o_overflow_error  out  1  sticky; a complete byte arrived while the FIFO was full
- o_parity_error  out  1  sticky; parity mismatch
- o_frame_error  out  1  sticky; stop bit sampled low

Behaviour:
- Reset values:
  - state = IDLE
  - o_rx_strb_en = 0
  - all three error flags = 0
  - FIFO empty, o_fifo_rd_data = 0
  - synchroniser flops = 1
- Line input: i_uart_rx passes through SYNC_STAGES flops, giving rx_s. All sampling uses rx_s.
- Strobe counter: 4-bit, counts i_rx_strb pulses. It is cleared on every state entry. A "mid-bit" sample is taken on the strobe where the count equals 7; a "bit end" is the strobe where the count equals 15.
- IDLE:
  - A 1->0 edge on rx_s moves to START.
  - On that edge the block latches data_bits, use_parity, parity seed and stop_bits.
  - Configuration changes mid-frame have no effect on the frame in progress.
- START:
  - At mid-bit, rx_s = 1 is a glitch: return to IDLE with no error.
  - At mid-bit, rx_s = 0 clears the counter (re-centres) and moves to DATA.
- DATA:
  - Each 16 strobes, sample rx_s, shift it into the shift register MSB-first-in (so the result is LSB-first on the line), and XOR it into the running parity.
  - After data_bits samples, go to PARITY if use_parity, else to STOP.
  - When the frame ends, right-justify the byte (shift right by 8 - data_bits).
- PARITY:
  - Sample after 16 strobes.
  - Set parity_bad when the sample differs from the running parity (seeded with i_parity).
- STOP:
  - Sample after 16 strobes.
  - rx_s = 1: write the byte to the FIFO if not full, else set o_overflow_error and drop the byte. If parity_bad, set o_parity_error; the byte is still written. Then go to IDLE.
  - rx_s = 0: set o_frame_error, discard the byte, go to BREAK_WAIT.
- Stop bits: the second stop bit (i_stop_bits = 1) is not checked. The receiver returns to IDLE after the first stop sample, so back-to-back frames are accepted.
- BREAK_WAIT: stay until rx_s = 1, then go to IDLE. A held-low break therefore produces exactly one frame error and no FIFO writes.
- FIFO write: exactly one cycle, on the cycle after the stop sample. Writes and TX activity are independent.
- Simultaneous events:
  - i_error_clear in the same cycle as a new error: the set wins.
  - i_fifo_clear in the same cycle as a write: the clear wins and the byte is lost, with no overflow flagged.
  - i_fifo_rd_en while empty is ignored.
  - Read and write in the same cycle while full: the write succeeds and no overflow is flagged.
- Reset mid-frame aborts immediately to IDLE. No partial byte is written.

Decomposition:
- uart_pkg:
  - rx_state_t (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT), 3-bit
  - OVERSAMPLE = 16, MID_SAMPLE = 7, MIN_DATA_BITS = 5
  - the data-bits encoding shared with the TX stage
- Sub-module: reuse the existing sync_fifo_with_clear with DATA_WIDTH = 8, DEPTH = FIFO_DEPTH, EXTRA_OUTPUT_REGISTER = 0. The synchroniser stays inline.

Test Plan:
- 8N1 frame, 0xA5, strobe every clock -> exactly one FIFO write of 0xA5; o_fifo_empty deasserts; all errors 0; o_rx_strb_en low again after the stop sample.
- 7E1 (i_data_bits = 2, i_use_parity = 1, i_parity = 0), data 0x55 with a wrong parity bit 1 -> o_fifo_rd_data = 0x55, o_parity_error = 1; a following i_error_clear pulse -> flag 0.
- 5N2, data 0x1F then back-to-back 0x03 -> FIFO holds 0x1F then 0x03, with upper bits 0.
- Start glitch: rx low for 4 strobes, then high -> no write, no error, state IDLE.
- Break: rx held low for 30 bit times -> o_frame_error = 1, zero writes; after rx goes high, the next frame 0x3C is received correctly.
- Overflow: 17 frames with FIFO_DEPTH = 16 and no reads -> o_fifo_full = 1, o_overflow_error = 1, the first 16 bytes are intact; i_fifo_clear -> o_fifo_empty = 1.
